// File: rtl/hazard_stall_controller.sv
// Hazard sequencer for the 5-stage RV32 pipeline: load-use bubbles, taken-branch flushes,
// memory-busy freeze, plus saturating stall/flush counters and a sticky memory-timeout flag.
//
// state      | meaning
// RUN        | normal issue; load-use hazards detected here
// LOAD_STALL | extra load-use bubbles remaining in bubbleCnt
module hazard_stall_controller #(
  parameter int LOAD_LATENCY = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RD,
  input  logic [4:0]       IF_ID_RS1,
  input  logic [4:0]       IF_ID_RS2,
  input  logic             Use_RS1,
  input  logic             Use_RS2,
  input  logic             Branch_Taken,
  input  logic             EX_MEM_MemAccess,
  input  logic             Mem_Ready,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             Pipe_Freeze,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout_err
);

  typedef enum logic {RUN, LOAD_STALL} stateT;

  localparam logic [2:0] BUBBLE_INIT = 3'(LOAD_LATENCY - 1);
  localparam logic [7:0] WAIT_LIMIT  = 8'(MEM_TIMEOUT - 1);

  stateT      state, nextState;
  logic [2:0] bubbleCnt, nextBubble;
  logic [7:0] waitCnt;
  logic       memBusy, loadUse, flushEvt;

  assign memBusy = EX_MEM_MemAccess & ~Mem_Ready;
  assign loadUse = ID_EX_MemRead & (ID_EX_RD != 5'd0) &
                   ((Use_RS1 & (ID_EX_RD == IF_ID_RS1)) | (Use_RS2 & (ID_EX_RD == IF_ID_RS2)));

  always_comb begin
    nextState   = state;
    nextBubble  = bubbleCnt;
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    Pipe_Freeze = 1'b0;
    flushEvt    = 1'b0;
    if (rst) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
    end else if (memBusy) begin
      // EX is frozen, so a pending taken branch is still asserted when the freeze lifts
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      Pipe_Freeze = 1'b1;
    end else if (Branch_Taken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      flushEvt    = 1'b1;
      nextState   = RUN;
      nextBubble  = 3'd0;
    end else if (state == LOAD_STALL) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      nextBubble  = bubbleCnt - 3'd1;
      if (bubbleCnt <= 3'd1) nextState = RUN;
    end else if (loadUse) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      if (LOAD_LATENCY > 1) begin
        nextState  = LOAD_STALL;
        nextBubble = BUBBLE_INIT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      bubbleCnt       <= 3'd0;
      waitCnt         <= 8'd0;
      stall_cycles    <= '0;
      flush_count     <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state     <= nextState;
      bubbleCnt <= nextBubble;
      if (!memBusy)              waitCnt <= 8'd0;
      else if (waitCnt != 8'hFF) waitCnt <= waitCnt + 8'd1;
      if (memBusy && (waitCnt >= WAIT_LIMIT)) mem_timeout_err <= 1'b1;
      if (!PCWrite && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (flushEvt && (flush_count != '1))  flush_count  <= flush_count + 1'b1;
    end
  end

endmodule
